// File: rtl/cache_data_nway.sv
// N-way set-associative cache data array with byte-writable CPU port and
// beat-serial refill / writeback sequencers facing the AXI bridge.
module cache_data_nway #(
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 8,
  parameter int INDEX_W    = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_en,
  input  logic [3:0]                      req_wen,
  input  logic [31:0]                     req_addr,
  input  logic [31:0]                     req_wdata,
  input  logic [WAYS-1:0]                 hit,
  output logic [31:0]                     rdata,
  output logic                            rdata_valid,
  output logic                            busy,
  input  logic                            wb_start,
  input  logic [$clog2(WAYS)-1:0]         wb_way,
  input  logic [INDEX_W-1:0]              wb_index,
  output logic                            wb_valid,
  output logic [31:0]                     wb_data,
  output logic                            wb_last,
  input  logic                            wb_ready,
  input  logic                            refill_start,
  input  logic [$clog2(WAYS)-1:0]         refill_way,
  input  logic [INDEX_W-1:0]              refill_index,
  input  logic                            refill_valid,
  input  logic [31:0]                     refill_data,
  output logic                            refill_ready,
  output logic                            refill_done
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int BANKS  = WAYS * LINE_WORDS;
  localparam int SETS   = 2 ** INDEX_W;
  localparam int BANK_W = WAY_W + WORD_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_WB_RD, S_WB_OUT, S_REFILL, S_DONE} state_t;

  function automatic logic [WAY_W-1:0] onehot_to_idx(input logic [WAYS-1:0] oh);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (oh[i]) idx = idx | WAY_W'(i);
    end
    return idx;
  endfunction

  state_t              r_state;
  logic [WORD_W-1:0]   r_cnt;
  logic [WAY_W-1:0]    r_way;
  logic [INDEX_W-1:0]  r_index;
  logic [31:0]         r_rdata, r_wb_data;
  logic                r_rdata_valid, r_busy, r_wb_valid, r_wb_last, r_refill_ready, r_refill_done;
  logic [31:0]         r_mem  [BANKS][SETS];
  logic [31:0]         r_line [LINE_WORDS];

  logic                w_cpu_rd, w_cpu_wr, w_rf_wr, w_we;
  logic [WORD_W-1:0]   w_off, w_cnt_nxt;
  logic [INDEX_W-1:0]  w_idx, w_we_idx;
  logic [BANK_W-1:0]   w_cpu_bank, w_we_bank;
  logic [3:0]          w_we_be;
  logic [31:0]         w_we_data;
  logic                w_unused_addr;

  assign w_off         = req_addr[WORD_W+1:2];
  assign w_idx         = req_addr[INDEX_W+WORD_W+1:WORD_W+2];
  assign w_unused_addr = ^{req_addr[31:INDEX_W+WORD_W+2], req_addr[1:0]};
  assign w_cpu_bank    = {onehot_to_idx(hit), w_off};
  assign w_cpu_rd      = (r_state == S_IDLE) & req_en & (|hit) & (req_wen == 4'b0000);
  assign w_cpu_wr      = (r_state == S_IDLE) & req_en & (|hit) & (req_wen != 4'b0000);
  assign w_rf_wr       = (r_state == S_REFILL) & refill_valid;
  assign w_cnt_nxt     = r_cnt + WORD_W'(1);

  // Single write port: refill beats and CPU writes never coincide (CPU only in IDLE)
  always_comb begin
    w_we      = 1'b0;
    w_we_bank = '0;
    w_we_idx  = '0;
    w_we_be   = 4'b0000;
    w_we_data = 32'h0;
    if (w_rf_wr) begin
      w_we      = 1'b1;
      w_we_bank = {r_way, r_cnt};
      w_we_idx  = r_index;
      w_we_be   = 4'b1111;
      w_we_data = refill_data;
    end else begin
      w_we      = w_cpu_wr;
      w_we_bank = w_cpu_bank;
      w_we_idx  = w_idx;
      w_we_be   = req_wen;
      w_we_data = req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_we_be[b]) r_mem[w_we_bank][w_we_idx][8*b +: 8] <= w_we_data[8*b +: 8];
      end
    end
  end

  // Whole-line snapshot of the victim; array reads are read-first w.r.t. the write port
  always_ff @(posedge clk) begin
    if (r_state == S_WB_RD) begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        r_line[w] <= r_mem[{r_way, WORD_W'(w)}][r_index];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_way          <= '0;
      r_index        <= '0;
      r_rdata        <= 32'h0;
      r_rdata_valid  <= 1'b0;
      r_busy         <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_last      <= 1'b0;
      r_wb_data      <= 32'h0;
      r_refill_ready <= 1'b0;
      r_refill_done  <= 1'b0;
    end else begin
      r_rdata_valid <= w_cpu_rd;
      r_rdata       <= w_cpu_rd ? r_mem[w_cpu_bank][w_idx] : 32'h0;
      case (r_state)
        S_IDLE: begin
          if (wb_start) begin
            r_way   <= wb_way;
            r_index <= wb_index;
            r_busy  <= 1'b1;
            r_state <= S_WB_RD;
          end else if (refill_start) begin
            r_way          <= refill_way;
            r_index        <= refill_index;
            r_cnt          <= '0;
            r_busy         <= 1'b1;
            r_refill_ready <= 1'b1;
            r_state        <= S_REFILL;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_WB_RD: begin
          r_wb_data  <= r_mem[{r_way, {WORD_W{1'b0}}}][r_index];
          r_wb_valid <= 1'b1;
          r_wb_last  <= 1'b0;
          r_cnt      <= '0;
          r_state    <= S_WB_OUT;
        end
        S_WB_OUT: begin
          if (wb_ready) begin
            if (r_cnt == LAST_WORD) begin
              r_wb_valid <= 1'b0;
              r_wb_last  <= 1'b0;
              r_wb_data  <= 32'h0;
              r_cnt      <= '0;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_cnt     <= w_cnt_nxt;
              r_wb_data <= r_line[w_cnt_nxt];
              r_wb_last <= (w_cnt_nxt == LAST_WORD);
            end
          end
        end
        S_REFILL: begin
          if (refill_valid) begin
            r_cnt <= w_cnt_nxt;
            if (r_cnt == LAST_WORD) begin
              r_refill_ready <= 1'b0;
              r_refill_done  <= 1'b1;
              r_state        <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_refill_done <= 1'b0;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          r_state        <= S_IDLE;
          r_busy         <= 1'b0;
          r_wb_valid     <= 1'b0;
          r_refill_ready <= 1'b0;
          r_refill_done  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata        = r_rdata;
  assign rdata_valid  = r_rdata_valid;
  assign busy         = r_busy;
  assign wb_valid     = r_wb_valid;
  assign wb_data      = r_wb_data;
  assign wb_last      = r_wb_last;
  assign refill_ready = r_refill_ready;
  assign refill_done  = r_refill_done;

endmodule

// File: tb/tb_cache_data_nway.sv
// Directed bench for cache_data_nway: a 2-way/8-word and a 4-way/16-word instance
// share one stimulus set; sel picks which instance is driven and observed.
module tb_cache_data_nway;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_en, wb_start, refill_start, refill_valid, wb_ready;
  logic [3:0]  req_wen, hit;
  logic [31:0] req_addr, req_wdata, refill_data;
  logic [1:0]  wb_way, refill_way;
  logic [6:0]  wb_index, refill_index;

  logic [31:0] a_rdata, b_rdata, a_wb_data, b_wb_data;
  logic        a_rdata_valid, b_rdata_valid, a_busy, b_busy, a_wb_valid, b_wb_valid;
  logic        a_wb_last, b_wb_last, a_refill_ready, b_refill_ready, a_refill_done, b_refill_done;
  logic [31:0] rdata, wb_data;
  logic        rdata_valid, busy, wb_valid, wb_last, refill_ready, refill_done;

  int          checks = 0;
  int          errors = 0;
  int          lw, wordw;
  logic [3:0]  hv;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  cache_data_nway #(.WAYS(2), .LINE_WORDS(8), .INDEX_W(7)) u_a (
    .clk(clk), .rst(rst), .req_en(req_en & ~sel), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .hit(hit[1:0]), .rdata(a_rdata), .rdata_valid(a_rdata_valid), .busy(a_busy),
    .wb_start(wb_start & ~sel), .wb_way(wb_way[0:0]), .wb_index(wb_index[6:0]), .wb_valid(a_wb_valid),
    .wb_data(a_wb_data), .wb_last(a_wb_last), .wb_ready(wb_ready), .refill_start(refill_start & ~sel),
    .refill_way(refill_way[0:0]), .refill_index(refill_index[6:0]), .refill_valid(refill_valid & ~sel),
    .refill_data(refill_data), .refill_ready(a_refill_ready), .refill_done(a_refill_done));

  cache_data_nway #(.WAYS(4), .LINE_WORDS(16), .INDEX_W(6)) u_b (
    .clk(clk), .rst(rst), .req_en(req_en & sel), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .hit(hit), .rdata(b_rdata), .rdata_valid(b_rdata_valid), .busy(b_busy),
    .wb_start(wb_start & sel), .wb_way(wb_way), .wb_index(wb_index[5:0]), .wb_valid(b_wb_valid),
    .wb_data(b_wb_data), .wb_last(b_wb_last), .wb_ready(wb_ready), .refill_start(refill_start & sel),
    .refill_way(refill_way), .refill_index(refill_index[5:0]), .refill_valid(refill_valid & sel),
    .refill_data(refill_data), .refill_ready(b_refill_ready), .refill_done(b_refill_done));

  assign rdata        = sel ? b_rdata        : a_rdata;
  assign rdata_valid  = sel ? b_rdata_valid  : a_rdata_valid;
  assign busy         = sel ? b_busy         : a_busy;
  assign wb_valid     = sel ? b_wb_valid     : a_wb_valid;
  assign wb_data      = sel ? b_wb_data      : a_wb_data;
  assign wb_last      = sel ? b_wb_last      : a_wb_last;
  assign refill_ready = sel ? b_refill_ready : a_refill_ready;
  assign refill_done  = sel ? b_refill_done  : a_refill_done;

  typedef struct {
    int          word;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic        use_hit;
    logic        exp_valid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg=%0d actual=%h expected=%h", name, sel, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input string name, input int word, input logic [3:0] wen, input logic [31:0] wd,
                        input logic use_hit, input logic exp_valid, input logic [31:0] exp_rdata);
    req_addr  = (32'd5 << (wordw + 2)) | (32'(word) << 2);
    req_wen   = wen;
    req_wdata = wd;
    hit       = use_hit ? hv : 4'b0000;
    req_en    = 1'b1;
    tick();
    req_en = 1'b0;
    hit    = 4'b0000;
    check({name, "_valid"}, rdata_valid, exp_valid);
    check({name, "_rdata"}, rdata, exp_rdata);
  endtask

  task automatic do_refill(input logic [1:0] way, input logic [31:0] base, input int stop_after);
    int beats = 0;
    int dones = 0;
    int cyc   = 0;
    logic acc;
    refill_way   = way;
    refill_index = 7'd5;
    refill_start = 1'b1;
    tick();
    refill_start = 1'b0;
    check("refill_ready_up", refill_ready, 1'b1);
    while (beats < lw && cyc < 200 && beats != stop_after) begin
      refill_valid = (cyc % 2 == 0);
      refill_data  = base + 32'(beats);
      acc = refill_valid & refill_ready;
      tick();
      cyc++;
      if (acc) beats++;
      if (refill_done) dones++;
    end
    refill_valid = 1'b0;
    if (stop_after < 0) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        if (refill_done) dones++;
      end
      check("refill_beats", 32'(beats), 32'(lw));
      check("refill_done_pulses", 32'(dones), 32'd1);
      check("refill_ready_down", refill_ready, 1'b0);
      check("refill_busy_clear", busy, 1'b0);
      for (int w = 0; w < lw; w++) model[w] = base + 32'(w);
    end
  endtask

  // contend=1 also raises refill_start with wb_start and pokes the CPU port while busy
  task automatic do_wb(input logic [1:0] way, input logic contend);
    int beats = 0;
    int cyc   = 0;
    logic acc;
    wb_way       = way;
    wb_index     = 7'd5;
    wb_start     = 1'b1;
    refill_start = contend;
    refill_way   = way;
    refill_index = 7'd5;
    tick();
    wb_start     = 1'b0;
    refill_start = 1'b0;
    refill_valid = contend;
    check("wb_rd_valid_low", wb_valid, 1'b0);
    check("wb_busy", busy, 1'b1);
    while (beats < lw && cyc < 200) begin
      wb_ready = (cyc % 2 == 1);
      if (wb_valid) begin
        check("wb_data", wb_data, model[beats]);
        check("wb_last", wb_last, beats == lw - 1);
      end
      if (contend) begin
        check("contend_refill_ready", refill_ready, 1'b0);
        check("busy_rdata_valid", rdata_valid, 1'b0);
        req_en    = busy;
        req_wen   = (cyc % 2 == 0) ? 4'b1111 : 4'b0000;
        req_wdata = 32'hDEADBEEF;
        req_addr  = 32'd5 << (wordw + 2);
        hit       = hv;
      end
      acc = wb_valid & wb_ready;
      tick();
      cyc++;
      if (acc) beats++;
    end
    req_en       = 1'b0;
    hit          = 4'b0000;
    wb_ready     = 1'b0;
    refill_valid = 1'b0;
    check("wb_beats", 32'(beats), 32'(lw));
    check("wb_valid_end", wb_valid, 1'b0);
    check("wb_busy_end", busy, 1'b0);
    tick();
    tick();
    check("wb_no_refill_ready", refill_ready, 1'b0);
    check("wb_still_idle", busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rdata"}, rdata, 32'h0);
    check({name, "_rdata_valid"}, rdata_valid, 1'b0);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_wb_valid"}, wb_valid, 1'b0);
    check({name, "_wb_last"}, wb_last, 1'b0);
    check({name, "_wb_data"}, wb_data, 32'h0);
    check({name, "_refill_ready"}, refill_ready, 1'b0);
    check({name, "_refill_done"}, refill_done, 1'b0);
  endtask

  task automatic run_cfg(input logic s, input logic [31:0] base, input logic [1:0] way, input logic [3:0] h);
    sel   = s;
    lw    = s ? 16 : 8;
    wordw = s ? 4 : 3;
    hv    = h;
    do_refill(way, base, -1);
    tbl[0] = '{5,      4'b0000, 32'h0,        1'b1, 1'b1, base + 32'd5};
    tbl[1] = '{5,      4'b0000, 32'h0,        1'b0, 1'b0, 32'h0};
    tbl[2] = '{0,      4'b0000, 32'h0,        1'b1, 1'b1, base};
    tbl[3] = '{lw - 1, 4'b0000, 32'h0,        1'b1, 1'b1, base + 32'(lw - 1)};
    tbl[4] = '{5,      4'b0011, 32'h1234FFFF, 1'b1, 1'b0, 32'h0};
    tbl[5] = '{5,      4'b0000, 32'h0,        1'b1, 1'b1, 32'h0000FFFF};
    tbl[6] = '{1,      4'b1100, 32'hCAFE5555, 1'b1, 1'b0, 32'h0};
    tbl[7] = '{1,      4'b0000, 32'h0,        1'b1, 1'b1, 32'hCAFE0000 | (base + 32'd1)};
    for (int i = 0; i < 8; i++) begin
      cpu_op($sformatf("vec%0d", i), tbl[i].word, tbl[i].wen, tbl[i].wdata,
             tbl[i].use_hit, tbl[i].exp_valid, tbl[i].exp_rdata);
    end
    model[5] = 32'h0000FFFF;
    model[1] = 32'hCAFE0000 | (base + 32'd1);
    do_wb(way, 1'b0);
    do_wb(way, 1'b1);
    cpu_op("after_busy_word0", 0, 4'b0000, 32'h0, 1'b1, 1'b1, model[0]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; req_en = 1'b0; req_wen = 4'b0000; req_addr = 32'h0; req_wdata = 32'h0;
    hit = 4'b0000; wb_start = 1'b0; wb_way = 2'd0; wb_index = 7'd0; wb_ready = 1'b0;
    refill_start = 1'b0; refill_way = 2'd0; refill_index = 7'd0; refill_valid = 1'b0; refill_data = 32'h0;
    lw = 8; wordw = 3; hv = 4'b0010;
    tick();
    tick();
    check_reset_outputs("rst_a");
    sel = 1'b1;
    #1;
    check_reset_outputs("rst_b");
    sel = 1'b0;
    rst = 1'b0;
    tick();

    run_cfg(1'b0, 32'hA0, 2'd1, 4'b0010);
    run_cfg(1'b1, 32'hB0, 2'd3, 4'b1000);

    // reset in the middle of a refill, then a clean refill of the same line
    sel = 1'b0; lw = 8; wordw = 3; hv = 4'b0001;
    do_refill(2'd0, 32'hD0, 3);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    tick();
    check("midrst_idle", busy, 1'b0);
    for (int w = 0; w < 3; w++) begin
      cpu_op($sformatf("partial%0d", w), w, 4'b0000, 32'h0, 1'b1, 1'b1, 32'hD0 + 32'(w));
    end
    do_refill(2'd0, 32'hE0, -1);
    cpu_op("refill_again3", 3, 4'b0000, 32'h0, 1'b1, 1'b1, 32'hE3);
    cpu_op("refill_again7", 7, 4'b0000, 32'h0, 1'b1, 1'b1, 32'hE7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
